// File: rtl/regmem_pkg.sv
// Shared opcode constants and FSM state encoding for the register/memory
// interface controller.
package regmem_pkg;

  localparam logic [1:0] OP_WR_DATA = 2'd0;
  localparam logic [1:0] OP_REG2MEM = 2'd1;
  localparam logic [1:0] OP_MEM2REG = 2'd2;
  localparam logic [1:0] OP_MEM2OUT = 2'd3;
  // Reading memory to data_out is harmless, so it doubles as the bus idle value.
  localparam logic [1:0] OP_IDLE    = OP_MEM2OUT;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin grant. The last winner is remembered only when
// the grant is actually consumed (en).
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  logic last_grant;

  always_comb begin
    gnt = req;
    if (req[0] && req[1]) begin
      gnt = last_grant ? 2'b01 : 2'b10;
    end
  end

  // Reset to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (en) begin
      last_grant <= gnt[1];
    end
  end

endmodule

// File: rtl/regmem_arbiter.sv
// Two-port front end for the register/memory interface: arbitrates commands,
// holds each one on the interface for HOLD_CYC cycles, then pulses a completion.
//
// state | meaning
// IDLE  | idle command on bus, granted requester sees ready
// ISSUE | latched command driven on bus, hold counter running
// RESP  | one-cycle completion, bus back to idle command
module regmem_arbiter
  import regmem_pkg::*;
#(
  parameter int DATA_W   = 4,
  parameter int ADDR_W   = 4,
  parameter int HOLD_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [1:0]        req0_opcode,
  input  logic [ADDR_W-1:0] req0_reg_adrs,
  input  logic [ADDR_W-1:0] req0_mem_adrs,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [1:0]        req1_opcode,
  input  logic [ADDR_W-1:0] req1_reg_adrs,
  input  logic [ADDR_W-1:0] req1_mem_adrs,
  input  logic [DATA_W-1:0] req1_data,
  output logic [1:0]        if_opcode,
  output logic [ADDR_W-1:0] if_reg_adrs,
  output logic [ADDR_W-1:0] if_mem_adrs,
  output logic [DATA_W-1:0] if_data_in,
  input  logic [DATA_W-1:0] if_data_out,
  output logic              rsp_valid,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy
);

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYC - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [1:0]        op_q;
  logic [ADDR_W-1:0] reg_adrs_q;
  logic [ADDR_W-1:0] mem_adrs_q;
  logic [DATA_W-1:0] data_q;
  logic              id_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic [1:0]        gnt;
  logic              in_idle;
  logic              hs;
  logic              sel;

  assign in_idle    = (state_q == IDLE);
  assign req0_ready = in_idle && gnt[0];
  assign req1_ready = in_idle && gnt[1];
  assign hs         = (req0_valid && req0_ready) || (req1_valid && req1_ready);
  assign sel        = gnt[1];
  assign rsp_data   = rsp_data_q;

  rr_arbiter2 u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .req   ({req1_valid, req0_valid}),
    .en    (hs),
    .gnt   (gnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    if_opcode   = OP_IDLE;
    if_reg_adrs = '0;
    if_mem_adrs = '0;
    if_data_in  = '0;
    rsp_valid   = 1'b0;
    rsp_id      = 1'b0;
    busy        = 1'b1;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (hs) state_d = ISSUE;
      end
      ISSUE: begin
        if_opcode   = op_q;
        if_reg_adrs = reg_adrs_q;
        if_mem_adrs = mem_adrs_q;
        if_data_in  = data_q;
        if (cnt_q == '0) state_d = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_id    = id_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Command capture, hold countdown and last-cycle response sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      op_q       <= OP_IDLE;
      reg_adrs_q <= '0;
      mem_adrs_q <= '0;
      data_q     <= '0;
      id_q       <= 1'b0;
      rsp_data_q <= '0;
    end else if (hs) begin
      cnt_q      <= HOLD_LOAD;
      op_q       <= sel ? req1_opcode   : req0_opcode;
      reg_adrs_q <= sel ? req1_reg_adrs : req0_reg_adrs;
      mem_adrs_q <= sel ? req1_mem_adrs : req0_mem_adrs;
      data_q     <= sel ? req1_data     : req0_data;
      id_q       <= sel;
    end else if (state_q == ISSUE) begin
      if (cnt_q == '0) begin
        rsp_data_q <= if_data_out;
      end else begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_regmem_arbiter.sv
// Self-checking bench for regmem_arbiter: directed table, contention, reset
// abort, random commands against a memory reference model, HOLD_CYC sweep.
module tb_regmem_arbiter;

  localparam int HOLD = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       r0_valid, r1_valid, r0_ready, r1_ready;
  logic [1:0] r0_op, r1_op;
  logic [3:0] r0_reg, r0_mem, r0_data, r1_reg, r1_mem, r1_data;
  logic [1:0] if_op;
  logic [3:0] if_reg, if_mem, if_din, if_dout, rsp_data;
  logic       rsp_valid, rsp_id, busy;

  regmem_arbiter #(.DATA_W(4), .ADDR_W(4), .HOLD_CYC(HOLD)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(r0_valid), .req0_ready(r0_ready), .req0_opcode(r0_op),
    .req0_reg_adrs(r0_reg), .req0_mem_adrs(r0_mem), .req0_data(r0_data),
    .req1_valid(r1_valid), .req1_ready(r1_ready), .req1_opcode(r1_op),
    .req1_reg_adrs(r1_reg), .req1_mem_adrs(r1_mem), .req1_data(r1_data),
    .if_opcode(if_op), .if_reg_adrs(if_reg), .if_mem_adrs(if_mem),
    .if_data_in(if_din), .if_data_out(if_dout),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
  );

  // Behavioural stand-in for the register/memory interface block.
  logic [3:0] env_mem [16];
  logic [3:0] env_reg [16];
  logic       env_init;
  assign if_dout = env_mem[if_mem];
  always @(posedge clk) begin
    if (env_init) begin
      for (int i = 0; i < 16; i++) begin
        env_mem[i] <= 4'd0;
        env_reg[i] <= 4'd0;
      end
    end else begin
      case (if_op)
        2'd0: env_mem[if_mem] <= if_din;
        2'd1: env_mem[if_mem] <= env_reg[if_reg];
        2'd2: env_reg[if_reg] <= env_mem[if_mem];
        default: ;
      endcase
    end
  end

  // Sweep instances: HOLD_CYC=1 (a) and HOLD_CYC=5 (b), fed identically.
  logic       sw_valid;
  logic [1:0] sw_op;
  logic [3:0] sw_reg, sw_mem, sw_data;
  logic       z1;
  logic [1:0] z2;
  logic [3:0] z4;
  logic       a_rdy0, a_rdy1, a_rv, a_rid, a_busy;
  logic       b_rdy0, b_rdy1, b_rv, b_rid, b_busy;
  logic [1:0] a_op, b_op;
  logic [3:0] a_reg, a_mem, a_din, a_rd, b_reg, b_mem, b_din, b_rd;

  regmem_arbiter #(.DATA_W(4), .ADDR_W(4), .HOLD_CYC(1)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(sw_valid), .req0_ready(a_rdy0), .req0_opcode(sw_op),
    .req0_reg_adrs(sw_reg), .req0_mem_adrs(sw_mem), .req0_data(sw_data),
    .req1_valid(z1), .req1_ready(a_rdy1), .req1_opcode(z2),
    .req1_reg_adrs(z4), .req1_mem_adrs(z4), .req1_data(z4),
    .if_opcode(a_op), .if_reg_adrs(a_reg), .if_mem_adrs(a_mem),
    .if_data_in(a_din), .if_data_out(~a_mem),
    .rsp_valid(a_rv), .rsp_id(a_rid), .rsp_data(a_rd), .busy(a_busy)
  );

  regmem_arbiter #(.DATA_W(4), .ADDR_W(4), .HOLD_CYC(5)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(sw_valid), .req0_ready(b_rdy0), .req0_opcode(sw_op),
    .req0_reg_adrs(sw_reg), .req0_mem_adrs(sw_mem), .req0_data(sw_data),
    .req1_valid(z1), .req1_ready(b_rdy1), .req1_opcode(z2),
    .req1_reg_adrs(z4), .req1_mem_adrs(z4), .req1_data(z4),
    .if_opcode(b_op), .if_reg_adrs(b_reg), .if_mem_adrs(b_mem),
    .if_data_in(b_din), .if_data_out(~b_mem),
    .rsp_valid(b_rv), .rsp_id(b_rid), .rsp_data(b_rd), .busy(b_busy)
  );

  int errors = 0;
  int checks = 0;
  bit last_p;

  logic [3:0] ref_mem [16];
  logic [3:0] ref_reg [16];

  typedef struct {
    bit         port;
    logic [1:0] op;
    logic [3:0] r;
    logic [3:0] m;
    logic [3:0] d;
    bit         chk_data;
    logic [3:0] exp_data;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: commands take effect atomically in accept order.
  function automatic logic [3:0] ref_apply(input logic [1:0] op, input logic [3:0] r,
                                           input logic [3:0] m, input logic [3:0] d);
    logic [3:0] rd;
    rd = 4'd0;
    case (op)
      2'd0: ref_mem[m] = d;
      2'd1: ref_mem[m] = ref_reg[r];
      2'd2: ref_reg[r] = ref_mem[m];
      default: rd = ref_mem[m];
    endcase
    return rd;
  endfunction

  task automatic drive(input bit p, input bit v, input logic [1:0] op,
                       input logic [3:0] r, input logic [3:0] m, input logic [3:0] d);
    if (p) begin
      r1_valid = v; r1_op = op; r1_reg = r; r1_mem = m; r1_data = d;
    end else begin
      r0_valid = v; r0_op = op; r0_reg = r; r0_mem = m; r0_data = d;
    end
  endtask

  task automatic do_cmd(input bit p, input logic [1:0] op, input logic [3:0] r,
                        input logic [3:0] m, input logic [3:0] d,
                        input bit chk_data, input logic [3:0] exp_d);
    bit got;
    got = 1'b0;
    @(negedge clk);
    drive(p, 1'b1, op, r, m, d);
    for (int k = 0; k < 10 && !got; k++) begin
      #1;
      if ((p ? r1_ready : r0_ready) === 1'b1) got = 1'b1;
      else @(negedge clk);
    end
    chk("ready_own", p ? r1_ready : r0_ready, 1);
    chk("ready_other", p ? r0_ready : r1_ready, 0);
    if (!got) begin
      drive(p, 1'b0, op, r, m, d);
      return;
    end
    last_p = p;
    @(negedge clk);
    drive(p, 1'b0, op, r, m, d);
    for (int i = 0; i < HOLD; i++) begin
      #1;
      chk("hold_opcode", if_op, op);
      chk("hold_mem_adrs", if_mem, m);
      chk("hold_reg_adrs", if_reg, r);
      chk("hold_data_in", if_din, d);
      chk("hold_rsp_valid", rsp_valid, 0);
      chk("hold_busy", busy, 1);
      chk("hold_ready", r0_ready | r1_ready, 0);
      @(negedge clk);
    end
    #1;
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_id", rsp_id, p);
    chk("resp_if_opcode", if_op, 3);
    if (chk_data) chk("rsp_data", rsp_data, exp_d);
    @(negedge clk);
    #1;
    chk("rsp_pulse_end", rsp_valid, 0);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    int   acc_p[$];
    int   acc_c[$];
    int   i0, i1;
    bit   pend0, pend1;
    bit   exp_first;

    vecs[0] = '{1'b0, 2'd0, 4'd0, 4'd5, 4'd9, 1'b0, 4'd0};
    vecs[1] = '{1'b1, 2'd0, 4'd0, 4'd3, 4'd7, 1'b0, 4'd0};
    vecs[2] = '{1'b1, 2'd3, 4'd0, 4'd3, 4'd0, 1'b1, 4'd7};
    vecs[3] = '{1'b0, 2'd2, 4'd2, 4'd3, 4'd0, 1'b0, 4'd0};
    vecs[4] = '{1'b1, 2'd1, 4'd2, 4'd4, 4'd0, 1'b0, 4'd0};
    vecs[5] = '{1'b0, 2'd3, 4'd0, 4'd4, 4'd0, 1'b1, 4'd7};

    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = 4'd0;
      ref_reg[i] = 4'd0;
    end
    last_p   = 1'b1;
    env_init = 1'b1;
    rst_n    = 1'b0;
    drive(0, 0, 2'd0, 4'd0, 4'd0, 4'd0);
    drive(1, 0, 2'd0, 4'd0, 4'd0, 4'd0);
    sw_valid = 0; sw_op = 0; sw_reg = 0; sw_mem = 0; sw_data = 0;
    z1 = 0; z2 = 0; z4 = 0;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_if_opcode", if_op, 3);
    chk("rst_if_mem", if_mem, 0);
    chk("rst_if_reg", if_reg, 0);
    chk("rst_if_din", if_din, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready0", r0_ready, 0);
    chk("rst_ready1", r1_ready, 0);
    env_init = 1'b0;
    rst_n    = 1'b1;

    // Directed table: single write, write/readback, reg round trip.
    for (int i = 0; i < 6; i++) begin
      void'(ref_apply(vecs[i].op, vecs[i].r, vecs[i].m, vecs[i].d));
      do_cmd(vecs[i].port, vecs[i].op, vecs[i].r, vecs[i].m, vecs[i].d,
             vecs[i].chk_data, vecs[i].exp_data);
    end

    // Contention: four commands per port, both valid continuously.
    exp_first = ~last_p;
    i0 = 0; i1 = 0; pend0 = 0; pend1 = 0;
    @(negedge clk);
    drive(0, 1, 2'd0, 4'd0, 4'd8, 4'd1);
    drive(1, 1, 2'd0, 4'd0, 4'd12, 4'd5);
    for (int c = 0; c < 80 && acc_p.size() < 8; c++) begin
      if (c > 0) @(negedge clk);
      if (pend0) begin
        pend0 = 0;
        drive(0, i0 < 4, 2'd0, 4'd0, 4'(8 + i0), 4'(1 + i0));
      end
      if (pend1) begin
        pend1 = 0;
        drive(1, i1 < 4, 2'd0, 4'd0, 4'(12 + i1), 4'(5 + i1));
      end
      #1;
      chk("dual_ready", r0_ready & r1_ready, 0);
      if (r0_valid && r0_ready) begin
        acc_p.push_back(0); acc_c.push_back(cyc);
        void'(ref_apply(2'd0, 4'd0, 4'(8 + i0), 4'(1 + i0)));
        i0++; pend0 = 1;
      end
      if (r1_valid && r1_ready) begin
        acc_p.push_back(1); acc_c.push_back(cyc);
        void'(ref_apply(2'd0, 4'd0, 4'(12 + i1), 4'(5 + i1)));
        i1++; pend1 = 1;
      end
    end
    @(negedge clk);
    drive(0, 0, 2'd0, 4'd0, 4'd0, 4'd0);
    drive(1, 0, 2'd0, 4'd0, 4'd0, 4'd0);
    chk("contention_count", acc_p.size(), 8);
    for (int k = 0; k < acc_p.size(); k++) begin
      chk("contention_order", acc_p[k], (int'(exp_first) + k) % 2);
      if (k > 0) chk("contention_spacing", acc_c[k] - acc_c[k-1], HOLD + 2);
    end
    if (acc_p.size() > 0) last_p = acc_p[acc_p.size()-1][0];
    repeat (HOLD + 3) @(negedge clk);

    // Readback of one contention write through the random-path checker.
    do_cmd(1, 2'd3, 4'd0, 4'd14, 4'd0, 1, ref_apply(2'd3, 4'd0, 4'd14, 4'd0));

    // Reset during the first ISSUE cycle of a port-0 write.
    @(negedge clk);
    drive(0, 1, 2'd0, 4'd0, 4'd6, 4'd11);
    #1;
    chk("abort_ready", r0_ready, 1);
    @(negedge clk);
    drive(0, 0, 2'd0, 4'd0, 4'd6, 4'd11);
    #1;
    chk("abort_issue_opcode", if_op, 0);
    rst_n = 1'b0;
    #1;
    chk("abort_if_opcode", if_op, 3);
    chk("abort_if_mem", if_mem, 0);
    chk("abort_busy", busy, 0);
    chk("abort_rsp_valid", rsp_valid, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < HOLD + 2; c++) begin
      #1;
      chk("abort_no_rsp", rsp_valid, 0);
      @(negedge clk);
    end
    // last_grant back to reset value: port 0 wins a tie; drop before handshake.
    r0_valid = 1; r1_valid = 1;
    #1;
    chk("tie_ready0", r0_ready, 1);
    chk("tie_ready1", r1_ready, 0);
    #1;
    r0_valid = 0; r1_valid = 0;
    do_cmd(1, 2'd3, 4'd0, 4'd6, 4'd0, 1, ref_apply(2'd3, 4'd0, 4'd6, 4'd0));

    // Random commands against the reference model.
    for (int n = 0; n < 24; n++) begin
      bit         p;
      logic [1:0] op;
      logic [3:0] r, m, d, e;
      p  = 1'($urandom_range(0, 1));
      op = 2'($urandom_range(0, 3));
      r  = 4'($urandom_range(0, 15));
      m  = 4'($urandom_range(0, 15));
      d  = 4'($urandom_range(0, 15));
      e  = ref_apply(op, r, m, d);
      do_cmd(p, op, r, m, d, op == 2'd3, e);
    end

    // HOLD_CYC sweep: 1 and 5 cycle holds.
    for (int n = 0; n < 2; n++) begin
      @(negedge clk);
      sw_op = 2'(n); sw_reg = 4'(n); sw_mem = 4'(9 + n); sw_data = 4'(5 + n);
      sw_valid = 1;
      #1;
      chk("sweep_a_ready", a_rdy0, 1);
      chk("sweep_b_ready", b_rdy0, 1);
      @(negedge clk);
      sw_valid = 0;
      for (int c = 0; c < 7; c++) begin
        #1;
        chk("sweep_a_opcode", a_op, (c < 1) ? n : 3);
        chk("sweep_a_rsp_valid", a_rv, c == 1);
        chk("sweep_b_opcode", b_op, (c < 5) ? n : 3);
        chk("sweep_b_rsp_valid", b_rv, c == 5);
        if (c < 5) chk("sweep_b_mem", b_mem, 9 + n);
        if (c == 1) chk("sweep_a_rsp_data", a_rd, 4'(~(9 + n)));
        if (c == 5) chk("sweep_b_rsp_data", b_rd, 4'(~(9 + n)));
        @(negedge clk);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
